// File: rtl/ppg_pkg.sv
// Shared fixed-point definitions for the rho producer: formats, FSM states and
// sign-magnitude <-> two's complement conversion helpers.
package ppg_pkg;

  localparam int Q    = 15;
  localparam int N    = 32;
  localparam int PM_W = 2*N - 2 - Q;   // magnitude width of a Q-format product
  localparam int AW   = 2*N;           // accumulator width

  localparam logic [N-1:0] Q_ONE  = N'(1) << Q;
  localparam logic [N-1:0] SM_MAX = {1'b0, {(N-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    BIAS = 2'd2,
    DONE = 2'd3
  } rho_state_t;

  typedef struct packed {
    logic [N-1:0] sm;
    logic         ovf;
  } sm_sat_t;

  function automatic logic [AW-1:0] sm2tc(input logic sign, input logic [PM_W-1:0] mag);
    logic [AW-1:0] ext;
    ext = AW'(mag);
    return sign ? -ext : ext;
  endfunction

  // Zero always comes out as +0; out-of-range magnitudes clamp to all ones.
  function automatic sm_sat_t tc2sm_sat(input logic [AW-1:0] v);
    logic          neg;
    logic [AW-1:0] mag;
    sm_sat_t       r;
    neg = v[AW-1];
    mag = neg ? -v : v;
    if (mag > {{N{1'b0}}, SM_MAX}) begin
      r.sm  = {neg, {(N-1){1'b1}}};
      r.ovf = 1'b1;
    end else begin
      r.sm  = (mag == '0) ? '0 : {neg, mag[N-2:0]};
      r.ovf = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/sm_qmul.sv
// Combinational sign-magnitude Q-format multiply; magnitude truncated toward zero.
module sm_qmul
  import ppg_pkg::*;
(
  input  logic [N-1:0]    x,
  input  logic [N-1:0]    y,
  output logic            p_sign,
  output logic [PM_W-1:0] p_mag
);

  localparam int PW = 2*N - 2;

  logic [PW-1:0] full;

  assign full   = PW'(x[N-2:0]) * PW'(y[N-2:0]);
  assign p_mag  = PM_W'(full >> Q);
  // A zero magnitude (including -0 operands) is reported as +0.
  assign p_sign = (p_mag != '0) & (x[N-1] ^ y[N-1]);

endmodule

// File: rtl/calc_rho.sv
// rho = sum_i(a_ij*r_i) + A_norm2*xhat_j, streamed over M beats and delivered
// as a saturated sign-magnitude value with a one-cycle rho_valid pulse.
module calc_rho
  import ppg_pkg::*;
#(
  parameter int M = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] xhat,
  input  logic [N-1:0] A_norm2,
  input  logic         col_valid,
  output logic         col_ready,
  input  logic [N-1:0] a_ij,
  input  logic [N-1:0] r_i,
  output logic [N-1:0] rho,
  output logic         rho_valid,
  output logic         ovf,
  output logic         busy
);

  localparam int CW = $clog2(M + 1);

  rho_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [N-1:0]  xhat_q, xhat_d;
  logic [N-1:0]  an2_q, an2_d;
  logic [N-1:0]  rho_q, rho_d;
  logic          ovf_q, ovf_d;
  logic          rho_valid_q, rho_valid_d;
  logic          col_ready_q, col_ready_d;

  logic [N-1:0]    op_x, op_y;
  logic            p_sign;
  logic [PM_W-1:0] p_mag;
  logic [AW-1:0]   prod_tc;
  logic            xfer;
  sm_sat_t         sat;

  // One shared multiplier: column beats in ACC, the bias term in BIAS.
  assign op_x = (state_q == BIAS) ? an2_q  : a_ij;
  assign op_y = (state_q == BIAS) ? xhat_q : r_i;

  sm_qmul u_mul (
    .x      (op_x),
    .y      (op_y),
    .p_sign (p_sign),
    .p_mag  (p_mag)
  );

  assign prod_tc = sm2tc(p_sign, p_mag);
  assign xfer    = col_valid & col_ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    xhat_d      = xhat_q;
    an2_d       = an2_q;
    rho_d       = rho_q;
    ovf_d       = ovf_q;
    rho_valid_d = 1'b0;
    col_ready_d = 1'b0;
    sat         = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          xhat_d  = xhat;
          an2_d   = A_norm2;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        col_ready_d = 1'b1;
        if (xfer) begin
          acc_d = acc_q + prod_tc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(M - 1)) begin
            col_ready_d = 1'b0;
            state_d     = BIAS;
          end
        end
      end
      BIAS: begin
        // Result is registered here so rho and rho_valid are both live in DONE.
        acc_d       = acc_q + prod_tc;
        sat         = tc2sm_sat(acc_d);
        rho_d       = sat.sm;
        ovf_d       = sat.ovf;
        rho_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      xhat_q      <= '0;
      an2_q       <= '0;
      rho_q       <= '0;
      ovf_q       <= 1'b0;
      rho_valid_q <= 1'b0;
      col_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      xhat_q      <= xhat_d;
      an2_q       <= an2_d;
      rho_q       <= rho_d;
      ovf_q       <= ovf_d;
      rho_valid_q <= rho_valid_d;
      col_ready_q <= col_ready_d;
    end
  end

  assign col_ready = col_ready_q;
  assign rho       = rho_q;
  assign rho_valid = rho_valid_q;
  assign ovf       = ovf_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_calc_rho.sv
// Directed bench for calc_rho with M=4, Q=15, N=32 (1.0 = 0x00008000).
module tb_calc_rho;

  localparam int M = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] xhat, A_norm2, a_ij, r_i;
  logic        col_valid;
  logic        col_ready;
  logic [31:0] rho;
  logic        rho_valid, ovf, busy;

  calc_rho #(.M(M)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .xhat      (xhat),
    .A_norm2   (A_norm2),
    .col_valid (col_valid),
    .col_ready (col_ready),
    .a_ij      (a_ij),
    .r_i       (r_i),
    .rho       (rho),
    .rho_valid (rho_valid),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Observations from the most recent run_op
  int          rv_k;
  int          pulses;
  logic [31:0] rv_rho;
  logic        rv_ovf;
  logic        late_ready;
  logic        busy_post;

  // Cycle k=0 carries start; beats are offered from k=1. gap_len idle cycles are
  // inserted after the 2nd transfer; restart_k (if >=0) pulses start again.
  task automatic run_op(input logic [31:0] xh, input logic [31:0] an,
                        input logic [M-1:0][31:0] av, input logic [M-1:0][31:0] rv,
                        input int gap_len, input int restart_k);
    int beats = 0;
    int gap   = gap_len;
    int k     = 0;
    bit done  = 0;
    rv_k = -1; pulses = 0; rv_rho = '0; rv_ovf = 1'b0;
    late_ready = 1'b0; busy_post = 1'b1;
    while (k < 60 && !done) begin
      start   = (k == 0) || (k == restart_k);
      xhat    = xh;
      A_norm2 = an;
      if (beats == 2 && gap > 0) begin
        col_valid = 1'b0;
        gap--;
      end else if (beats < M && k >= 1) begin
        col_valid = 1'b1;
        a_ij      = av[beats];
        r_i       = rv[beats];
      end else begin
        col_valid = 1'b0;
      end
      @(negedge clk);
      if (col_valid && col_ready) beats++;
      else if (beats == M && col_ready) late_ready = 1'b1;
      if (rho_valid) begin
        pulses++;
        if (rv_k < 0) begin
          rv_k = k; rv_rho = rho; rv_ovf = ovf;
        end
      end
      if (rv_k >= 0 && k == rv_k + 1) busy_post = busy;
      @(posedge clk); #1;
      k++;
      if (rv_k >= 0 && k > rv_k + 3) done = 1;
    end
    start = 1'b0; col_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (rho !== 32'h0)   begin failures++; $display("FAIL reset_rho got=%h exp=00000000", rho); end
    checks++; if (rho_valid !== 0) begin failures++; $display("FAIL reset_rho_valid got=%b exp=0", rho_valid); end
    checks++; if (ovf !== 0)       begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (col_ready !== 0) begin failures++; $display("FAIL reset_col_ready got=%b exp=0", col_ready); end
    checks++; if (busy !== 0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic_sum();
    run_op(32'h0, 32'h8000, {4{32'h8000}}, {4{32'h4000}}, 0, -1);
    checks++; if (rv_k !== 7)            begin failures++; $display("FAIL basic_latency got=%0d exp=7", rv_k); end
    checks++; if (rv_rho !== 32'h10000)  begin failures++; $display("FAIL basic_rho got=%h exp=00010000", rv_rho); end
    checks++; if (rv_ovf !== 0)          begin failures++; $display("FAIL basic_ovf got=%b exp=0", rv_ovf); end
    checks++; if (pulses !== 1)          begin failures++; $display("FAIL basic_pulses got=%0d exp=1", pulses); end
    checks++; if (rho !== 32'h10000)     begin failures++; $display("FAIL basic_rho_hold got=%h exp=00010000", rho); end
  endtask

  task automatic test_signed_bias();
    run_op(32'h2000, 32'h20000, {4{32'h8000}}, {4{32'h80004000}}, 0, -1);
    checks++; if (rv_rho !== 32'h80008000) begin failures++; $display("FAIL signed_rho got=%h exp=80008000", rv_rho); end
    checks++; if (rv_k !== 7)              begin failures++; $display("FAIL signed_latency got=%0d exp=7", rv_k); end
  endtask

  task automatic test_stalls();
    run_op(32'h0, 32'h8000, {4{32'h8000}}, {4{32'h4000}}, 3, -1);
    checks++; if (rv_k !== 10)            begin failures++; $display("FAIL stall_latency got=%0d exp=10", rv_k); end
    checks++; if (rv_rho !== 32'h10000)   begin failures++; $display("FAIL stall_rho got=%h exp=00010000", rv_rho); end
    checks++; if (late_ready !== 1'b0)    begin failures++; $display("FAIL stall_ready_after_last got=%b exp=0", late_ready); end
  endtask

  task automatic test_saturation();
    run_op(32'h0, 32'h0, {4{32'h40000000}}, {4{32'h40000000}}, 0, -1);
    checks++; if (rv_rho !== 32'h7FFFFFFF) begin failures++; $display("FAIL sat_rho got=%h exp=7fffffff", rv_rho); end
    checks++; if (rv_ovf !== 1'b1)         begin failures++; $display("FAIL sat_ovf got=%b exp=1", rv_ovf); end
    checks++; if (ovf !== 1'b1)            begin failures++; $display("FAIL sat_ovf_hold got=%b exp=1", ovf); end
    run_op(32'h0, 32'h8000, {4{32'h8000}}, {4{32'h4000}}, 0, -1);
    checks++; if (rv_ovf !== 1'b0)         begin failures++; $display("FAIL sat_clear_ovf got=%b exp=0", rv_ovf); end
    checks++; if (rv_rho !== 32'h10000)    begin failures++; $display("FAIL sat_clear_rho got=%h exp=00010000", rv_rho); end
  endtask

  task automatic test_cancellation();
    run_op(32'h0, 32'h8000, {4{32'h8000}},
           {32'h80004000, 32'h4000, 32'h80004000, 32'h4000}, 0, -1);
    checks++; if (rv_rho !== 32'h0) begin failures++; $display("FAIL cancel_rho got=%h exp=00000000", rv_rho); end
    checks++; if (rv_ovf !== 1'b0)  begin failures++; $display("FAIL cancel_ovf got=%b exp=0", rv_ovf); end
  endtask

  task automatic test_start_ignored();
    run_op(32'h0, 32'h8000, {4{32'h8000}}, {4{32'h4000}}, 0, 3);
    checks++; if (pulses !== 1)         begin failures++; $display("FAIL acc_start_pulses got=%0d exp=1", pulses); end
    checks++; if (rv_k !== 7)           begin failures++; $display("FAIL acc_start_latency got=%0d exp=7", rv_k); end
    checks++; if (rv_rho !== 32'h10000) begin failures++; $display("FAIL acc_start_rho got=%h exp=00010000", rv_rho); end
  endtask

  task automatic test_back_to_back();
    // start raised during the rho_valid cycle must not launch a new run
    run_op(32'h0, 32'h8000, {4{32'h8000}}, {4{32'h4000}}, 0, 7);
    checks++; if (rv_k !== 7)         begin failures++; $display("FAIL b2b_latency got=%0d exp=7", rv_k); end
    checks++; if (busy_post !== 1'b0) begin failures++; $display("FAIL b2b_busy_after_done got=%b exp=0", busy_post); end
    checks++; if (pulses !== 1)       begin failures++; $display("FAIL b2b_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_mid_reset();
    int beats = 0;
    int guard = 0;
    int pulses_after = 0;
    int busy_seen = 0;
    start = 1'b1; col_valid = 1'b0; xhat = 32'h0; A_norm2 = 32'h8000;
    @(posedge clk); #1;
    start = 1'b0; col_valid = 1'b1; a_ij = 32'h8000; r_i = 32'h4000;
    while (beats < 2 && guard < 20) begin
      @(negedge clk);
      if (col_valid && col_ready) beats++;
      @(posedge clk); #1;
      guard++;
    end
    checks++; if (beats !== 2) begin failures++; $display("FAIL midrst_beats got=%0d exp=2", beats); end
    rst_n = 1'b0;
    #1;
    checks++; if (col_ready !== 0)  begin failures++; $display("FAIL midrst_col_ready got=%b exp=0", col_ready); end
    checks++; if (busy !== 0)       begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (rho !== 32'h0)    begin failures++; $display("FAIL midrst_rho got=%h exp=00000000", rho); end
    checks++; if (rho_valid !== 0)  begin failures++; $display("FAIL midrst_rho_valid got=%b exp=0", rho_valid); end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rho_valid) pulses_after++;
      if (busy) busy_seen++;
      @(posedge clk); #1;
    end
    col_valid = 1'b0;
    checks++; if (pulses_after !== 0) begin failures++; $display("FAIL midrst_late_pulse got=%0d exp=0", pulses_after); end
    checks++; if (busy_seen !== 0)    begin failures++; $display("FAIL midrst_busy_after got=%0d exp=0", busy_seen); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; col_valid = 1'b0;
    xhat = '0; A_norm2 = '0; a_ij = '0; r_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_basic_sum();
    test_signed_bias();
    test_stalls();
    test_saturation();
    test_cancellation();
    test_start_ignored();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
